// File: rtl/alu_arbiter.sv
// Two-requester sequencer for a shared combinational ALU: arbitrates, holds ALU inputs for a
// per-opcode settle time, and returns a registered result. Optional: ALU_ARB_ROUND_ROBIN_EN.
module alu_arbiter #(
    parameter int MUL_CYCLES  = 4,
    parameter int BASE_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic [31:0] OP1_0,
    input  logic [31:0] OP2_0,
    input  logic [5:0]  OPRN_0,
    input  logic [31:0] OP1_1,
    input  logic [31:0] OP2_1,
    input  logic [5:0]  OPRN_1,
    output logic        ACK0,
    output logic        ACK1,
    output logic        DONE0,
    output logic        DONE1,
    output logic [31:0] RESULT,
    output logic        RESULT_ZERO,
    output logic        BUSY,
    output logic [31:0] ALU_OP1,
    output logic [31:0] ALU_OP2,
    output logic [5:0]  ALU_OPRN,
    input  logic [31:0] ALU_OUT,
    input  logic        ALU_ZERO
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Counter load values are settle cycles minus one: the grant edge itself is the first cycle.
    localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] BASE_LOAD = 4'(BASE_CYCLES - 1);
    localparam logic [5:0] OPRN_MUL  = 6'h03;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        last_r, last_s;
    logic        owner_r, owner_s;
    logic        ack0_r, ack0_s, ack1_r, ack1_s;
    logic        done0_r, done0_s, done1_r, done1_s;
    logic [31:0] result_r, result_s;
    logic        zero_r, zero_s;
    logic [31:0] alu_op1_r, alu_op1_s, alu_op2_r, alu_op2_s;
    logic [5:0]  alu_oprn_r, alu_oprn_s;
    logic        grant1_s;
    logic [5:0]  sel_oprn_s;

    // Winner selection: requester 1 wins alone, or on a tie when round-robin favours it.
    always_comb begin
        grant1_s = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (REQ1 && (!REQ0 || !last_r)) begin
            grant1_s = 1'b1;
        end else begin
            grant1_s = 1'b0;
        end
`else
        if (REQ1 && !REQ0) begin
            grant1_s = 1'b1;
        end else begin
            grant1_s = 1'b0;
        end
`endif
        if (grant1_s) begin
            sel_oprn_s = OPRN_1;
        end else begin
            sel_oprn_s = OPRN_0;
        end
    end

    // Next-state and next-output logic for the IDLE/EXEC sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        last_s     = last_r;
        owner_s    = owner_r;
        ack0_s     = 1'b0;
        ack1_s     = 1'b0;
        done0_s    = 1'b0;
        done1_s    = 1'b0;
        result_s   = result_r;
        zero_s     = zero_r;
        alu_op1_s  = alu_op1_r;
        alu_op2_s  = alu_op2_r;
        alu_oprn_s = alu_oprn_r;
        case (state_r)
            ST_IDLE: begin
                if (REQ0 || REQ1) begin
                    owner_s    = grant1_s;
                    last_s     = grant1_s;
                    alu_oprn_s = sel_oprn_s;
                    state_s    = ST_EXEC;
                    if (sel_oprn_s == OPRN_MUL) begin
                        cnt_s = MUL_LOAD;
                    end else begin
                        cnt_s = BASE_LOAD;
                    end
                    if (grant1_s) begin
                        alu_op1_s = OP1_1;
                        alu_op2_s = OP2_1;
                        ack1_s    = 1'b1;
                    end else begin
                        alu_op1_s = OP1_0;
                        alu_op2_s = OP2_0;
                        ack0_s    = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    result_s = ALU_OUT;
                    zero_s   = ALU_ZERO;
                    state_s  = ST_IDLE;
                    if (owner_r) begin
                        done1_s = 1'b1;
                    end else begin
                        done0_s = 1'b1;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State and output registers; reset drops any operation in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            last_r     <= 1'b1;
            owner_r    <= 1'b0;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            done0_r    <= 1'b0;
            done1_r    <= 1'b0;
            result_r   <= 32'd0;
            zero_r     <= 1'b0;
            alu_op1_r  <= 32'd0;
            alu_op2_r  <= 32'd0;
            alu_oprn_r <= 6'd0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            last_r     <= last_s;
            owner_r    <= owner_s;
            ack0_r     <= ack0_s;
            ack1_r     <= ack1_s;
            done0_r    <= done0_s;
            done1_r    <= done1_s;
            result_r   <= result_s;
            zero_r     <= zero_s;
            alu_op1_r  <= alu_op1_s;
            alu_op2_r  <= alu_op2_s;
            alu_oprn_r <= alu_oprn_s;
        end
    end

    assign ACK0        = ack0_r;
    assign ACK1        = ack1_r;
    assign DONE0       = done0_r;
    assign DONE1       = done1_r;
    assign RESULT      = result_r;
    assign RESULT_ZERO = zero_r;
    assign BUSY        = (state_r == ST_EXEC);
    assign ALU_OP1     = alu_op1_r;
    assign ALU_OP2     = alu_op2_r;
    assign ALU_OPRN    = alu_oprn_r;

endmodule
